// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares the single DDR controller request port between
// NPORTS requesters. Registered arbitration, optional bus lock for
// back-to-back transfers, and a per-transfer acknowledge timeout.
//
// Build option:
//   DDR_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                          undefined -> round-robin starting after the last owner
module ddr_port_arbiter #(
  parameter int NPORTS  = 2,
  parameter int OWNER_W = 1,
  parameter int ADR_W   = 25,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORTS-1:0]         m_req,
  input  logic [NPORTS-1:0]         m_we,
  input  logic [NPORTS-1:0]         m_lock,
  input  logic [NPORTS*ADR_W-1:0]   m_adr,
  input  logic [NPORTS*DAT_W-1:0]   m_dat_w,
  output logic [NPORTS-1:0]         m_ack,
  output logic [NPORTS-1:0]         m_err,
  output logic [DAT_W-1:0]          m_dat_r,
  output logic                      s_req,
  output logic                      s_we,
  output logic [ADR_W-1:0]          s_adr,
  output logic [DAT_W-1:0]          s_dat_w,
  input  logic                      s_ack,
  input  logic [DAT_W-1:0]          s_dat_r,
  output logic [OWNER_W-1:0]        owner,
  output logic                      busy
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUS    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [OWNER_W-1:0]   owner_q,   owner_d;
  logic                 lock_q,    lock_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 s_req_q,   s_req_d;
  logic                 s_we_q,    s_we_d;
  logic [ADR_W-1:0]     s_adr_q,   s_adr_d;
  logic [DAT_W-1:0]     s_dat_w_q, s_dat_w_d;
  logic [NPORTS-1:0]    m_ack_q,   m_ack_d;
  logic [NPORTS-1:0]    m_err_q,   m_err_d;
  logic [DAT_W-1:0]     m_dat_r_q, m_dat_r_d;

  logic [NPORTS-1:0]    req_avail;
  logic                 arb_found;
  logic [OWNER_W-1:0]   arb_win;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 tmo_hit;
  logic                 bus_done;
  logic                 issue;
  logic [OWNER_W-1:0]   issue_port;

  // One-hot pulse vector selecting a single port.
  function automatic logic [NPORTS-1:0] port_sel(input logic [OWNER_W-1:0] p);
    logic [NPORTS-1:0] v;
    v = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (OWNER_W'(i) == p) v[i] = 1'b1;
    end
    return v;
  endfunction

  // A port whose transfer is being acknowledged this cycle may still show its
  // old request; it is hidden from arbitration for that one cycle.
  assign req_avail = m_req & ~(m_ack_q | m_err_q);

  // The counter is advanced before comparison, so TIMEOUT is the number of
  // cycles s_req stays high before an abort.
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign tmo_hit  = (cnt_inc == CNT_W'(TIMEOUT));
  assign bus_done = (state_q == ST_BUS) && (s_ack || tmo_hit);

`ifdef DDR_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index wins last.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req_avail[i]) begin
        arb_found = 1'b1;
        arb_win   = OWNER_W'(i);
      end
    end
  end
`else
  logic [OWNER_W-1:0] rr_q, rr_d;

  // Round-robin: scan from farthest to nearest after rr so the nearest wins.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      if (req_avail[(int'(rr_q) + k) % NPORTS]) begin
        arb_found = 1'b1;
        arb_win   = OWNER_W'((int'(rr_q) + k) % NPORTS);
      end
    end
  end

  // The pointer moves to the owner whenever a transfer completes or aborts.
  always_comb begin
    rr_d = rr_q;
    if (bus_done) rr_d = owner_q;
  end

  // Pointer register; reset to the last port so port 0 is served first.
  always_ff @(posedge clk) begin
    if (!reset) rr_q <= OWNER_W'(NPORTS - 1);
    else        rr_q <= rr_d;
  end
`endif

  // Next-state and output logic for the IDLE / BUS / LOCKED controller.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    s_req_d    = s_req_q;
    s_we_d     = s_we_q;
    s_adr_d    = s_adr_q;
    s_dat_w_d  = s_dat_w_q;
    m_ack_d    = '0;
    m_err_d    = '0;
    m_dat_r_d  = m_dat_r_q;
    issue      = 1'b0;
    issue_port = arb_win;

    unique case (state_q)
      ST_IDLE: begin
        issue = arb_found;
      end

      ST_BUS: begin
        cnt_d = cnt_inc;
        if (s_ack) begin
          // Completion has priority over a timeout landing in the same cycle.
          s_req_d   = 1'b0;
          m_ack_d   = port_sel(owner_q);
          m_dat_r_d = s_dat_r;
          state_d   = lock_q ? ST_LOCKED : ST_IDLE;
        end else if (tmo_hit) begin
          s_req_d = 1'b0;
          m_err_d = port_sel(owner_q);
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_LOCKED: begin
        // Only the lock holder is considered; other ports wait.
        issue_port = owner_q;
        if (req_avail[owner_q]) begin
          issue = 1'b1;
        end else if (!m_lock[owner_q]) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Grant: capture the winner's transfer so later requester changes are ignored.
    if (issue) begin
      state_d   = ST_BUS;
      owner_d   = issue_port;
      lock_d    = m_lock[issue_port];
      cnt_d     = '0;
      s_req_d   = 1'b1;
      s_we_d    = m_we[issue_port];
      s_adr_d   = m_adr[issue_port*ADR_W +: ADR_W];
      s_dat_w_d = m_dat_w[issue_port*DAT_W +: DAT_W];
    end
  end

  // State and output registers; reset clears everything, aborting any transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_adr_q   <= '0;
      s_dat_w_q <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
      m_dat_r_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_adr_q   <= s_adr_d;
      s_dat_w_q <= s_dat_w_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_dat_r_q <= m_dat_r_d;
    end
  end

  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign m_dat_r = m_dat_r_q;
  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_adr   = s_adr_q;
  assign s_dat_w = s_dat_w_q;
  assign owner   = owner_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
